// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C bus arbiter
package i2c_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_COMPLETE
    } state_e;

    localparam int ADDR_W             = 8;
    localparam int DATA_W             = 8;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after ptr_i wins
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    int  idx;
    logic found;

    // scan requesters starting at the pointer, wrapping once around
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one I2C master engine among NREQ requesters; optional watchdog via I2C_ARB_TIMEOUT_EN
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NREQ-1:0]        REQ,
    input  logic [ADDR_W*NREQ-1:0] ADDR,
    input  logic [DATA_W*NREQ-1:0] DATA,
    output logic [NREQ-1:0]        GNT,
    output logic [NREQ-1:0]        DONE,
    output logic [NREQ-1:0]        ERR,
    output logic                   M_START,
    output logic [ADDR_W-1:0]      M_ADDR,
    output logic [DATA_W-1:0]      M_DATA,
    input  logic                   M_BUSY,
    input  logic                   M_DONE,
    input  logic                   M_NACK
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, win;
    logic [PW-1:0]     ptr_q, ptr_d, ptr_nxt;
    logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
    logic [DATA_W-1:0] data_q, data_d, sel_data;
    logic              start_q, start_d, nack_q, nack_d, tmo;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    // count cycles spent waiting; cleared in every other state
    always_comb wdog_d = (state_q == S_WAIT) ? wdog_q + 1'b1 : '0;
    assign tmo = (state_q == S_WAIT) && (wdog_q == WW'(TIMEOUT_CYCLES - 1));
    // watchdog register
    always_ff @(posedge CLK) wdog_q <= !RST_N ? '0 : wdog_d;
`else
    assign tmo = 1'b0;
`endif

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req_i (REQ),
        .ptr_i (ptr_q),
        .gnt_o (win)
    );

    // route the winner's address/data slice and the post-completion pointer
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        ptr_nxt  = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                sel_addr = ADDR[i*ADDR_W +: ADDR_W];
                sel_data = DATA[i*DATA_W +: DATA_W];
            end
            if (gnt_q[i]) ptr_nxt = PW'((i + 1) % NREQ);
        end
    end

    // transaction sequencing: grant, launch, wait for the engine, report
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        nack_d  = nack_q;
        start_d = 1'b0;
        case (state_q)
            S_IDLE: if (|REQ && !M_BUSY) begin
                state_d = S_LAUNCH;
                gnt_d   = win;
                addr_d  = sel_addr;
                data_d  = sel_data;
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                start_d = 1'b1;
            end
            S_WAIT: if (M_DONE) begin
                state_d = S_COMPLETE;
                nack_d  = M_NACK;
            end else if (tmo) begin
                state_d = S_COMPLETE;
                nack_d  = 1'b1;
            end
            S_COMPLETE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = ptr_nxt;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and output registers; reset aborts any transaction without a pulse
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            nack_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            nack_q  <= nack_d;
            start_q <= start_d;
        end
    end

    assign GNT     = gnt_q;
    assign DONE    = (state_q == S_COMPLETE) ? gnt_q : '0;
    assign ERR     = DONE & {NREQ{nack_q}};
    assign M_START = start_q;
    assign M_ADDR  = addr_q;
    assign M_DATA  = data_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed self-checking bench for i2c_bus_arbiter (NREQ=2, TIMEOUT_CYCLES=16)
module tb_i2c_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [1:0]  REQ;
    logic [15:0] ADDR, DATA;
    logic [1:0]  GNT, DONE, ERR;
    logic        M_START;
    logic [7:0]  M_ADDR, M_DATA;
    logic        M_BUSY, M_DONE, M_NACK;
    int          vectors = 0;
    int          errs    = 0;

    i2c_bus_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(16)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .ADDR    (ADDR),
        .DATA    (DATA),
        .GNT     (GNT),
        .DONE    (DONE),
        .ERR     (ERR),
        .M_START (M_START),
        .M_ADDR  (M_ADDR),
        .M_DATA  (M_DATA),
        .M_BUSY  (M_BUSY),
        .M_DONE  (M_DONE),
        .M_NACK  (M_NACK)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic contend(input logic [1:0] exp);
        tick();
        chk("cont_gnt", {6'd0, GNT}, {6'd0, exp});
        chk("cont_addr", M_ADDR, exp[0] ? 8'h11 : 8'h22);
        tick();
        chk("cont_start", {7'd0, M_START}, 8'd1);
        M_DONE = 1'b1;
        tick();
        M_DONE = 1'b0;
        chk("cont_done", {6'd0, DONE}, {6'd0, exp});
        tick();
        chk("cont_idle_gnt", {6'd0, GNT}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; REQ = '0; ADDR = '0; DATA = '0;
        M_BUSY = 1'b0; M_DONE = 1'b0; M_NACK = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        chk("rst_gnt", {6'd0, GNT}, 8'd0);
        chk("rst_done", {6'd0, DONE}, 8'd0);
        chk("rst_err", {6'd0, ERR}, 8'd0);
        chk("rst_start", {7'd0, M_START}, 8'd0);
        chk("rst_addr", M_ADDR, 8'd0);
        chk("rst_data", M_DATA, 8'd0);
        // single request from requester 0
        REQ = 2'b01; ADDR = 16'h0033; DATA = 16'h00A5;
        tick();
        chk("s_gnt", {6'd0, GNT}, 8'h01);
        chk("s_start_lat", {7'd0, M_START}, 8'd0);
        chk("s_addr", M_ADDR, 8'h33);
        chk("s_data", M_DATA, 8'hA5);
        REQ = 2'b00; ADDR = 16'h0077; DATA = 16'h0011;
        tick();
        chk("s_start", {7'd0, M_START}, 8'd1);
        chk("s_gnt_hold", {6'd0, GNT}, 8'h01);
        tick();
        chk("s_start_pulse", {7'd0, M_START}, 8'd0);
        M_DONE = 1'b1;
        tick();
        M_DONE = 1'b0;
        chk("s_done", {6'd0, DONE}, 8'h01);
        chk("s_err", {6'd0, ERR}, 8'h00);
        chk("s_addr_kept", M_ADDR, 8'h33);
        chk("s_data_kept", M_DATA, 8'hA5);
        tick();
        chk("s_gnt_drop", {6'd0, GNT}, 8'd0);
        chk("s_done_pulse", {6'd0, DONE}, 8'd0);
        // M_DONE while idle is ignored
        M_DONE = 1'b1;
        tick();
        M_DONE = 1'b0;
        chk("idle_mdone", {6'd0, DONE}, 8'd0);
        tick();
        chk("idle_mdone2", {6'd0, DONE}, 8'd0);
        // NACK on requester 1 (pointer is 1 now)
        REQ = 2'b10; ADDR = 16'h5A00; DATA = 16'hC300;
        tick();
        chk("n_gnt", {6'd0, GNT}, 8'h02);
        chk("n_addr", M_ADDR, 8'h5A);
        chk("n_data", M_DATA, 8'hC3);
        REQ = 2'b00;
        tick();
        M_DONE = 1'b1; M_NACK = 1'b1;
        tick();
        M_DONE = 1'b0; M_NACK = 1'b0;
        chk("n_done", {6'd0, DONE}, 8'h02);
        chk("n_err", {6'd0, ERR}, 8'h02);
        tick();
        chk("n_err_pulse", {6'd0, ERR}, 8'd0);
        // contention from pointer 0
        REQ = 2'b11; ADDR = 16'h2211; DATA = 16'h4433;
        contend(2'b01);
        contend(2'b10);
        contend(2'b01);
        contend(2'b10);
        REQ = 2'b00;
        tick();
        // busy master holds off the grant
        REQ = 2'b01; M_BUSY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("busy_nogrant", {6'd0, GNT}, 8'd0);
        end
        M_BUSY = 1'b0;
        tick();
        chk("busy_gnt", {6'd0, GNT}, 8'h01);
        REQ = 2'b00; M_BUSY = 1'b1;
        tick();
        M_DONE = 1'b1;
        tick();
        M_DONE = 1'b0; M_BUSY = 1'b0;
        chk("busy_done", {6'd0, DONE}, 8'h01);
        tick();
        // reset while waiting on requester 1 (pointer is 1)
        REQ = 2'b10;
        tick();
        chk("r_gnt", {6'd0, GNT}, 8'h02);
        REQ = 2'b00;
        tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("r_gnt0", {6'd0, GNT}, 8'd0);
        chk("r_done0", {6'd0, DONE}, 8'd0);
        chk("r_err0", {6'd0, ERR}, 8'd0);
        chk("r_start0", {7'd0, M_START}, 8'd0);
        chk("r_addr0", M_ADDR, 8'd0);
        chk("r_data0", M_DATA, 8'd0);
        M_DONE = 1'b1;
        tick();
        M_DONE = 1'b0;
        chk("r_nodone", {6'd0, DONE}, 8'd0);
        REQ = 2'b11;
        tick();
        chk("r_ptr0", {6'd0, GNT}, 8'h01);
        REQ = 2'b00;
        tick();
`ifdef I2C_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t_wait", {6'd0, DONE}, 8'd0);
        end
        tick();
        chk("t_done", {6'd0, DONE}, 8'h01);
        chk("t_err", {6'd0, ERR}, 8'h01);
        tick();
        chk("t_idle", {6'd0, GNT}, 8'd0);
`else
        for (int i = 0; i < 40; i++) tick();
        chk("nt_wait_done", {6'd0, DONE}, 8'd0);
        chk("nt_wait_gnt", {6'd0, GNT}, 8'h01);
        M_DONE = 1'b1;
        tick();
        M_DONE = 1'b0;
        chk("nt_done", {6'd0, DONE}, 8'h01);
        chk("nt_err", {6'd0, ERR}, 8'h00);
        tick();
        chk("nt_idle", {6'd0, GNT}, 8'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
